// File: rtl/uart_defs.sv
// uart_defs: register map, status bit positions and receiver FSM states
package uart_defs;
    localparam logic RX_DATA = 1'b0;
    localparam logic RX_STAT = 1'b1;
    localparam int RDRF_B = 0;
    localparam int OVR_B = 1;
    localparam int FE_B = 2;
    localparam int IE_B = 7;
    localparam int OVERSAMPLE = 16;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
endpackage

// File: rtl/uart_rx_tick.sv
// uart_rx_tick: free-running divider giving a one-cycle oversample tick enable
module uart_rx_tick #(
    parameter int DIV = 13,
    parameter int DIV_W = 8
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    logic [DIV_W-1:0] cnt;
    assign tick = cnt == DIV_W'(DIV - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with 16x oversampling and a data/status register pair
module uart_rx
    import uart_defs::*;
#(
    parameter int DIV = 13,
    parameter int DIV_W = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXD,
    input  logic       ADDR,
    input  logic       R,
    input  logic       W,
    input  logic [7:0] DIN,
    output logic [7:0] DOUT,
    output logic       IRQ
);
    localparam logic [3:0] MID = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);
    logic s1, s2, rxs, tick, r_q, rd_data, wr_stat, done, fe_set;
    logic rdrf, ovr, fe, ie, unused_din;
    logic [3:0] phase, phase_n;
    logic [2:0] bit_idx, bit_n;
    logic [7:0] shreg, sh_n, rxdata, stat;
    state_t state, state_n;
    assign rxs = s2;
    assign unused_din = ^{DIN[6:3], DIN[0]};
    uart_rx_tick #(.DIV(DIV), .DIV_W(DIV_W)) u_tick (.clk(CLK), .rst(RST), .tick(tick));
    always_ff @(posedge CLK or posedge RST)
        if (RST) {s2, s1} <= 2'b11;
        else {s2, s1} <= {s1, RXD};
    always_comb begin
        state_n = state;
        phase_n = phase;
        bit_n = bit_idx;
        sh_n = shreg;
        done = 1'b0;
        fe_set = 1'b0;
        if (tick) begin
            phase_n = phase + 4'd1;
            case (state)
                IDLE: if (!rxs) begin
                    state_n = START;
                    phase_n = '0;
                end
                START: if (phase == MID) begin
                    state_n = rxs ? IDLE : DATA;
                    phase_n = '0;
                    bit_n = '0;
                end
                // phase wraps 15 -> 0 on its own, so each data bit is 16 ticks
                DATA: if (phase == LAST) begin
                    sh_n = {rxs, shreg[7:1]};
                    bit_n = bit_idx + 3'd1;
                    state_n = bit_idx == 3'd7 ? STOP : DATA;
                end
                STOP: if (phase == LAST) begin
                    done = rxs;
                    fe_set = !rxs;
                    state_n = rxs ? IDLE : BREAK;
                end
                BREAK: if (rxs) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            state <= IDLE;
            phase <= '0;
            bit_idx <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            phase <= phase_n;
            bit_idx <= bit_n;
            shreg <= sh_n;
        end
    assign rd_data = !R && r_q && ADDR == RX_DATA;
    assign wr_stat = !W && ADDR == RX_STAT;
    // a read coinciding with completion frees the buffer, so the new byte loads without overrun
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            r_q <= 1'b1;
            rdrf <= 1'b0;
            ovr <= 1'b0;
            fe <= 1'b0;
            ie <= 1'b0;
            rxdata <= '0;
        end else begin
            r_q <= R;
            rdrf <= (done && (!rdrf || rd_data)) ? 1'b1 : rd_data ? 1'b0 : rdrf;
            rxdata <= (done && (!rdrf || rd_data)) ? shreg : rxdata;
            ovr <= (done && rdrf && !rd_data) ? 1'b1 : (wr_stat && DIN[OVR_B]) ? 1'b0 : ovr;
            fe <= fe_set ? 1'b1 : (wr_stat && DIN[FE_B]) ? 1'b0 : fe;
            ie <= wr_stat ? DIN[IE_B] : ie;
        end
    always_comb begin
        stat = '0;
        stat[RDRF_B] = rdrf;
        stat[OVR_B] = ovr;
        stat[FE_B] = fe;
        stat[IE_B] = ie;
    end
    assign DOUT = ADDR == RX_STAT ? stat : rxdata;
    assign IRQ = !(ie && (rdrf || ovr || fe));
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed plus randomized frames checked against a flag-level receiver model
module tb_uart_rx;
    localparam int DIV = 2;
    localparam int BIT = 16 * DIV;
    localparam int LAT_LO = 152 * DIV + 3;
    localparam int LAT_HI = 152 * DIV + DIV + 2;
    logic CLK = 1'b0, RST = 1'b1, RXD = 1'b1, ADDR = 1'b0, R = 1'b1, W = 1'b1;
    logic [7:0] DIN = '0;
    logic [7:0] DOUT;
    logic IRQ;
    int checks = 0, errors = 0;
    logic m_rdrf = 0, m_ovr = 0, m_fe = 0, m_ie = 0;
    logic [7:0] m_data = '0;

    uart_rx #(.DIV(DIV), .DIV_W(8)) dut (
        .CLK(CLK), .RST(RST), .RXD(RXD), .ADDR(ADDR), .R(R), .W(W),
        .DIN(DIN), .DOUT(DOUT), .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic exp_irq();
        return !(m_ie && (m_rdrf || m_ovr || m_fe));
    endfunction

    function automatic logic [7:0] exp_stat();
        return {m_ie, 4'b0, m_fe, m_ovr, m_rdrf};
    endfunction

    task automatic model_frame(input logic [7:0] b, input logic good);
        if (!good) m_fe = 1;
        else if (!m_rdrf) begin
            m_data = b;
            m_rdrf = 1;
        end else m_ovr = 1;
    endtask

    task automatic model_reset();
        m_rdrf = 0; m_ovr = 0; m_fe = 0; m_ie = 0; m_data = '0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        @(negedge CLK);
        R = 1; W = 1; ADDR = 1; #1;
        chk({tag, " status"}, DOUT, exp_stat());
        chk({tag, " irq"}, {7'b0, IRQ}, {7'b0, exp_irq()});
    endtask

    task automatic read_data(input string tag);
        logic [7:0] d;
        @(negedge CLK);
        ADDR = 0; R = 0; #1;
        d = DOUT;
        @(negedge CLK);
        R = 1;
        chk({tag, " data"}, d, m_data);
        m_rdrf = 0;
    endtask

    task automatic write_stat(input logic [7:0] d);
        @(negedge CLK);
        ADDR = 1; DIN = d; W = 0;
        @(negedge CLK);
        W = 1;
        m_ie = d[7];
        if (d[1]) m_ovr = 0;
        if (d[2]) m_fe = 0;
    endtask

    task automatic idle_cycles(input int n, input logic level);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            RXD = level;
        end
    endtask

    // Drives one full 10-bit frame, watching status for the RDRF rise; optionally reads data at iteration rd_at.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int rd_at,
                              output int rise, output logic irq_pre, output logic irq_at,
                              output logic [7:0] rd_val);
        logic [9:0] bits;
        logic prev_rdrf, prev_irq;
        bits = {stop, b, 1'b0};
        rise = -1; irq_pre = 1; irq_at = 1; rd_val = '0;
        prev_rdrf = 1; prev_irq = 1;
        for (int i = 0; i < 10 * BIT; i++) begin
            @(negedge CLK);
            if (i == rd_at) begin
                ADDR = 0; R = 0; #1;
                rd_val = DOUT;
            end else begin
                R = 1; ADDR = 1; #1;
                if (i > 0 && rise < 0 && DOUT[0] && !prev_rdrf) begin
                    rise = i; irq_at = IRQ; irq_pre = prev_irq;
                end
                prev_rdrf = DOUT[0]; prev_irq = IRQ;
            end
            RXD = bits[i / BIT];
        end
    endtask

    task automatic chk_latency(input string tag, input int rise);
        chk({tag, " latency"}, {7'b0, rise >= LAT_LO && rise <= LAT_HI}, 8'd1);
    endtask

    initial begin
        int rise, r1;
        logic ip, ia;
        logic [7:0] rv, b1, b2;
        repeat (3) @(negedge CLK);
        RST = 0;
        ADDR = 0; #1;
        chk("reset dout", DOUT, 8'h00);
        check_status("reset");

        send_frame(8'hA5, 1, -1, rise, ip, ia, rv);
        chk_latency("a5", rise);
        chk("a5 irq at rise", {7'b0, ia}, 8'd1);
        model_frame(8'hA5, 1);
        check_status("a5");
        read_data("a5");
        check_status("a5 after read");

        write_stat(8'h80);
        send_frame(8'h3C, 1, -1, rise, ip, ia, rv);
        chk_latency("3c", rise);
        chk("3c irq before rise", {7'b0, ip}, 8'd1);
        chk("3c irq at rise", {7'b0, ia}, 8'd0);
        model_frame(8'h3C, 1);
        check_status("3c");
        read_data("3c");
        check_status("3c after read");

        send_frame(8'h11, 1, -1, rise, ip, ia, rv);
        model_frame(8'h11, 1);
        send_frame(8'h22, 1, -1, rise, ip, ia, rv);
        model_frame(8'h22, 1);
        check_status("overrun");
        read_data("overrun");
        write_stat(8'h82);
        check_status("ovr clear");

        b1 = 8'($urandom);
        send_frame(b1, 0, -1, rise, ip, ia, rv);
        model_frame(b1, 0);
        check_status("framing");
        idle_cycles(3 * BIT, 0);
        idle_cycles(BIT, 1);
        send_frame(8'h55, 1, -1, rise, ip, ia, rv);
        model_frame(8'h55, 1);
        check_status("after break");
        read_data("after break");
        write_stat(8'h86);
        check_status("fe clear");

        idle_cycles(3 * DIV, 0);
        idle_cycles(10 * BIT, 1);
        check_status("glitch");
        b1 = 8'($urandom);
        send_frame(b1, 1, -1, rise, ip, ia, rv);
        model_frame(b1, 1);
        check_status("post glitch");
        read_data("post glitch");

        b1 = 8'($urandom);
        send_frame(b1, 1, -1, rise, ip, ia, rv);
        idle_cycles(5 * BIT, 0);
        @(negedge CLK);
        RST = 1; RXD = 1;
        model_reset();
        repeat (3) @(negedge CLK);
        RST = 0;
        check_status("mid reset");
        b1 = 8'($urandom);
        send_frame(b1, 1, -1, rise, ip, ia, rv);
        chk_latency("post reset", rise);
        model_frame(b1, 1);
        check_status("post reset");
        read_data("post reset");

        b1 = 8'($urandom);
        b2 = ~b1;
        send_frame(b1, 1, -1, r1, ip, ia, rv);
        model_frame(b1, 1);
        send_frame(b2, 1, r1 - 1, rise, ip, ia, rv);
        chk("overlap read", rv, b1);
        m_data = b2;
        check_status("overlap");
        read_data("overlap second");

        for (int k = 0; k < 4; k++) begin
            b1 = 8'($urandom);
            send_frame(b1, 1, -1, rise, ip, ia, rv);
            model_frame(b1, 1);
            check_status("random");
            if ($urandom_range(0, 1) == 1) read_data("random");
        end
        write_stat(8'h06);
        check_status("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
